// File: rtl/roy_autosynthesys.sv
// Registered WIDTH-bit Kogge-Stone adder with carry-out. One-cycle latency; propagate,
// generate and carry vectors are held in P, H and X1 for hierarchical inspection.
module roy_autosynthesys #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] X,
    output logic             C_out
);

    localparam int unsigned Levels = $clog2(WIDTH);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] H;
    logic [WIDTH-1:0] X1;

    assign p = A ^ B;
    assign g = A & B;

    // Each level owns its vectors so no signal feeds back into itself.
    for (genvar l = 0; l < Levels; l++) begin : g_level
        localparam int unsigned D = 1 << l;
        logic [WIDTH-1:0] g_in;
        logic [WIDTH-1:0] p_in;
        logic [WIDTH-1:0] g_out;
        logic [WIDTH-1:0] p_out;

        if (l == 0) begin : g_first
            assign g_in = g;
            assign p_in = p;
        end else begin : g_chain
            assign g_in = g_level[l-1].g_out;
            assign p_in = g_level[l-1].p_out;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_merge
                assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-D]);
                assign p_out[i] = p_in[i] & p_in[i-D];
            end else begin : g_pass
                assign g_out[i] = g_in[i];
                assign p_out[i] = p_in[i];
            end
        end
    end

    // Carry-in is zero, so the group generate over bits i..0 is the carry out of bit i.
    assign c = g_level[Levels-1].g_out;

    assign s[0]         = p[0];
    assign s[WIDTH-1:1] = p[WIDTH-1:1] ^ c[WIDTH-2:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            P     <= '0;
            H     <= '0;
            X1    <= '0;
            X     <= '0;
            C_out <= 1'b0;
        end else begin
            P     <= p;
            H     <= g;
            X1    <= c;
            X     <= s;
            C_out <= c[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_roy_autosynthesys.sv
// Directed bench for roy_autosynthesys: a 4-bit instance for hand-computed vectors and an
// exhaustive sweep, plus a 16-bit instance fed random pairs against a reference sum.
module tb_roy_autosynthesys;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [3:0]  x4;
    logic        c4;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] x16;
    logic        c16;

    int n_checks;
    int n_fail;

    roy_autosynthesys #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a4),
        .B     (b4),
        .X     (x4),
        .C_out (c4)
    );

    roy_autosynthesys #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a16),
        .B     (b16),
        .X     (x16),
        .C_out (c16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply a 4-bit pair, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b);
        a4 = a;
        b4 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  exp5;
        logic [16:0] exp17;
        logic [3:0]  av;
        logic [3:0]  bv;

        n_checks = 0;
        n_fail   = 0;
        a16      = 16'h1234;
        b16      = 16'hFFFF;

        // Reset held two cycles with live operands
        rst_n = 1'b0;
        step(4'h5, 4'h6);
        step(4'h5, 4'h6);
        chk("reset_x", {28'd0, x4}, 32'h0);
        chk("reset_cout", {31'd0, c4}, 32'h0);
        chk("reset_p", {28'd0, dut.P}, 32'h0);
        chk("reset_h", {28'd0, dut.H}, 32'h0);
        chk("reset_x1", {28'd0, dut.X1}, 32'h0);
        chk("reset_x16", {15'd0, c16, x16}, 32'h0);

        // Incrementing sweep: B = A + 2 mod 16
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            av = 4'(i);
            bv = 4'(i + 2);
            step(av, bv);
            exp5 = 5'(2 * i + 2);
            chk("sweep_x", {28'd0, x4}, {28'd0, exp5[3:0]});
            chk("sweep_cout", {31'd0, c4}, {31'd0, (i >= 7)});
            if (i == 3) begin
                chk("sweep3_p", {28'd0, dut.P}, 32'h6);
                chk("sweep3_h", {28'd0, dut.H}, 32'h1);
                chk("sweep3_x1", {28'd0, dut.X1}, 32'h7);
            end
        end

        // Full carry ripple
        step(4'hF, 4'h1);
        chk("ripple_x", {28'd0, x4}, 32'h0);
        chk("ripple_cout", {31'd0, c4}, 32'h1);
        chk("ripple_x1", {28'd0, dut.X1}, 32'hF);
        step(4'hF, 4'hF);
        chk("ff_x", {28'd0, x4}, 32'hE);
        chk("ff_cout", {31'd0, c4}, 32'h1);

        // Zero and identity
        step(4'h0, 4'h0);
        chk("zero_x", {28'd0, x4}, 32'h0);
        chk("zero_cout", {31'd0, c4}, 32'h0);
        step(4'hA, 4'h0);
        chk("ident_x", {28'd0, x4}, 32'hA);
        chk("ident_p", {28'd0, dut.P}, 32'hA);
        chk("ident_h", {28'd0, dut.H}, 32'h0);

        // Reset mid-stream
        step(4'h4, 4'h6);
        chk("pre_rst_x", {28'd0, x4}, 32'hA);
        rst_n = 1'b0;
        step(4'h7, 4'h9);
        chk("mid_rst_x", {28'd0, x4}, 32'h0);
        chk("mid_rst_cout", {31'd0, c4}, 32'h0);
        chk("mid_rst_p", {28'd0, dut.P}, 32'h0);
        chk("mid_rst_h", {28'd0, dut.H}, 32'h0);
        chk("mid_rst_x1", {28'd0, dut.X1}, 32'h0);
        rst_n = 1'b1;
        step(4'h2, 4'h3);
        chk("resume_x", {28'd0, x4}, 32'h5);
        chk("resume_cout", {31'd0, c4}, 32'h0);

        // Exhaustive 4-bit pairs alongside random 16-bit pairs
        for (int i = 0; i < 256; i++) begin
            av  = 4'(i >> 4);
            bv  = 4'(i);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            if (i == 0) begin
                a16 = 16'hFFFF;
                b16 = 16'h0001;
            end
            exp5  = {1'b0, av} + {1'b0, bv};
            exp17 = {1'b0, a16} + {1'b0, b16};
            step(av, bv);
            chk("exh4_sum", {27'd0, c4, x4}, {27'd0, exp5});
            chk("rand16_sum", {15'd0, c16, x16}, {15'd0, exp17});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
